// File: rtl/pe_array_stack_bus_upstream_arb_if.sv
// Per-PE upstream ports plus the single stack-bus upstream link.
// master = arbiter view, slave = PE array / stack-bus environment view.
interface pe_array_stack_bus_upstream_arb_if #(
    parameter int NUM_PE      = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int PE_ID_WIDTH = 6
);
    logic [NUM_PE-1:0]            pe_stu_valid;
    logic [2*NUM_PE-1:0]          pe_stu_cntl;
    logic [NUM_PE*DATA_WIDTH-1:0] pe_stu_data;
    logic [NUM_PE-1:0]            pe_stu_ready;
    logic                         stu_valid;
    logic                         stu_ready;
    logic [1:0]                   stu_cntl;
    logic [DATA_WIDTH-1:0]        stu_data;
    logic [PE_ID_WIDTH-1:0]       stu_pe_id;
    logic                         stu_err_no_sop;

    modport master (
        input  pe_stu_valid, pe_stu_cntl, pe_stu_data, stu_ready,
        output pe_stu_ready, stu_valid, stu_cntl, stu_data, stu_pe_id, stu_err_no_sop
    );

    modport slave (
        output pe_stu_valid, pe_stu_cntl, pe_stu_data, stu_ready,
        input  pe_stu_ready, stu_valid, stu_cntl, stu_data, stu_pe_id, stu_err_no_sop
    );
endinterface

// File: rtl/pe_array_stack_bus_upstream_arb.sv
// PE->stack upstream return path: round-robin arbitration with packet lock,
// serialised through a 2-entry FIFO onto one link, each beat tagged with its PE id.
module pe_array_stack_bus_upstream_arb #(
    parameter int NUM_PE      = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int PE_ID_WIDTH = 6
) (
    input  logic clk,
    input  logic reset_poweron,
    pe_array_stack_bus_upstream_arb_if.master bus
);
    localparam int ENTRY_W = 2 + DATA_WIDTH + PE_ID_WIDTH;

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t                 state_q, state_d;
    logic [PE_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [PE_ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic                   first_q, first_d;
    logic                   err_q, err_d;

    logic [ENTRY_W-1:0]     fifo_q [2];
    logic [ENTRY_W-1:0]     last_q;
    logic                   rd_ptr_q, wr_ptr_q;
    logic [1:0]             count_q;

    logic                   arb_found;
    logic [PE_ID_WIDTH-1:0] arb_id;
    int                     arb_idx;
    logic [NUM_PE-1:0]      ready_vec;
    logic [1:0]             beat_cntl;
    logic [DATA_WIDTH-1:0]  beat_data;
    logic                   push, pop;
    logic [ENTRY_W-1:0]     head;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_PE.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        arb_idx   = 0;
        for (int k = 0; k < NUM_PE; k++) begin
            arb_idx = int'(rr_ptr_q) + k;
            if (arb_idx >= NUM_PE) arb_idx = arb_idx - NUM_PE;
            if (!arb_found && bus.pe_stu_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_id    = PE_ID_WIDTH'(arb_idx);
            end
        end
    end

    // Ready comes only from registered state, never from any valid input.
    always_comb begin
        ready_vec = '0;
        if (state_q == ST_LOCK && count_q != 2'd2) ready_vec[grant_id_q] = 1'b1;
    end

    assign beat_cntl = bus.pe_stu_cntl[{grant_id_q, 1'b0} +: 2];
    assign beat_data = bus.pe_stu_data[grant_id_q * DATA_WIDTH +: DATA_WIDTH];
    assign push      = ready_vec[grant_id_q] && bus.pe_stu_valid[grant_id_q];
    assign pop       = (count_q != 2'd0) && bus.stu_ready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        first_d    = first_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d    = ST_LOCK;
                    grant_id_d = arb_id;
                    first_d    = 1'b1;
                end
            end
            ST_LOCK: begin
                if (push) begin
                    first_d = 1'b0;
                    if (first_q && !beat_cntl[0]) err_d = 1'b1;
                    if (beat_cntl[1]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_id_q == PE_ID_WIDTH'(NUM_PE - 1)) ? '0 : grant_id_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            first_q    <= first_d;
            err_q      <= err_d;
        end
    end

    // Beat entry layout: {cntl, data, pe_id}; last_q keeps stu_* stable while empty.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            last_q    <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {beat_cntl, beat_data, grant_id_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                last_q   <= fifo_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head               = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : last_q;
    assign bus.stu_valid      = (count_q != 2'd0);
    assign bus.stu_cntl       = head[ENTRY_W-1 -: 2];
    assign bus.stu_data       = head[PE_ID_WIDTH +: DATA_WIDTH];
    assign bus.stu_pe_id      = head[PE_ID_WIDTH-1:0];
    assign bus.pe_stu_ready   = ready_vec;
    assign bus.stu_err_no_sop = err_q;
endmodule
